input_buffer: RTL
=================

// Module: input_buffer
// PURPOSE
//  Per-port input flit FIFO of a NoC router; receives flits from the upstream router's output port.
//  Returns one credit pulse per dequeued flit; the pulse drives the upstream credit counter's incr_i.
//  Presents the head-of-line flit to the local route/crossbar stage and tracks packet framing.
// PARAMETERS
//  FLIT_W  32  flit width; bits [FLIT_W-1:FLIT_W-2] carry the flit type
//  DEPTH   5   FIFO entries; equals the upstream credit counter's reset value
// PORTS
//  clk           in   1                      clock, all state on posedge
//  rst           in   1                      asynchronous, active-low reset (asserted when 0)
//  flit_i        in   FLIT_W                 incoming flit
//  valid_i       in   1                      flit_i valid this cycle; no backpressure, credit-controlled
//  flit_o        out  FLIT_W                 head-of-line flit
//  valid_o       out  1                      FIFO non-empty
//  ready_i       in   1                      downstream consumes flit_o when valid_o && ready_i
//  credit_o      out  1                      one-cycle pulse, one per dequeued flit
//  occupancy_o   out  $clog2(DEPTH+1)        entries held
//  pkt_active_o  out  1                      packet in progress on dequeue side
//  err_o         out  2                      {framing_err, overflow_err}; see CONFIGURATION
// BEHAVIOUR
//  Reset (async, rst==0): wr/rd pointers=0, occupancy_o=0, valid_o=0, credit_o=0, FSM=IDLE, err_o=0.
//   flit_o content is don't-care while valid_o=0.
//  enq = valid_i && (!full || deq); deq = valid_o && ready_i.
//  Occupancy: +1 on enq only, -1 on deq only, unchanged on both. Never exceeds DEPTH or goes below 0.
//  Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
//  No bypass: flit written to empty FIFO appears on flit_o/valid_o the next cycle (latency 1).
//  flit_o is the stored head entry, stable while !deq.
//  Full && valid_i && !deq: flit dropped, state unchanged (protocol violation).
//  Full && valid_i && deq: both occur, occupancy stays DEPTH.
//  Empty && ready_i: no effect, no credit.
//  credit_o: registered; high exactly in the cycle after each deq, low otherwise.
//   Back-to-back deqs give back-to-back credit pulses.
//  Flit type (top 2 bits): 00 BODY, 01 HEAD, 10 TAIL, 11 SINGLE.
//  Framing FSM (advances on deq only):
//   IDLE   --deq HEAD-->   IN_PKT
//   IN_PKT --deq TAIL-->   IDLE
//   SINGLE in IDLE: stay IDLE.
//   Framing error: BODY/TAIL dequeued in IDLE, or HEAD/SINGLE dequeued in IN_PKT.
//    On error the state is unchanged, except HEAD in IN_PKT, which stays IN_PKT.
//  pkt_active_o = (state==IN_PKT), registered.
//  Reset mid-packet: all state cleared immediately, buffered flits discarded, no credits issued.
// CONFIGURATION
//  INBUF_ERR_FLAG_EN defined:
//   err_o[0] set on any dropped flit; err_o[1] set on any framing error.
//   Both bits sticky until reset.
//  INBUF_ERR_FLAG_EN undefined: err_o tied to 2'b00, no error registers; datapath behaviour identical.
// STRUCTURE
//  noc_pkg: flit_type_e enum (BODY/HEAD/TAIL/SINGLE), FLIT_W and DEPTH default localparams,
//   and the type-field extraction function.
//  Sub-module flit_fifo_mem: DEPTH x FLIT_W register array.
//   One write port and one async read port, indexed by the pointers.
//  Pointers, occupancy, credit and FSM logic live in input_buffer.
// TESTING
//  1 Reset: rst=0 mid-stream -> all outputs 0 the same cycle, FSM IDLE; after release, first flit valid 1 cycle after valid_i.
//  2 Fill: 5 flits, ready_i=0 -> occupancy_o=5, valid_o=1, flit_o=first flit, no credit_o.
//    6th flit -> dropped, occupancy 5, err_o=2'b01 (macro on) / 2'b00 (off).
//  3 Drain: ready_i=1 for 5 cycles -> flits out in order; credit_o high 5 consecutive cycles, each 1 cycle after deq.
//    valid_o=0 afterwards.
//  4 Full + simultaneous enq/deq -> occupancy stays 5, one credit, new flit appears 5 deqs later.
//  5 Framing: HEAD, BODY, TAIL dequeued -> pkt_active_o high 2 cycles then low, err_o[1]=0.
//    SINGLE -> pkt_active_o stays 0.
//  6 Framing error: BODY dequeued in IDLE -> err_o[1]=1 sticky (macro on); FSM stays IDLE.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type encoding, default sizing and the
// helper that decodes a flit's type field.
//
// Contents:
//   FlitWDefault  default flit width (type field in the top two bits)
//   DepthDefault  default input FIFO depth (matches the upstream credit reset value)
//   flit_type_e   BODY / HEAD / TAIL / SINGLE encoding
//   flit_type_of  converts the two type bits of a flit into flit_type_e
package noc_pkg;

  localparam int unsigned FlitWDefault = 32;
  localparam int unsigned DepthDefault = 5;

  typedef enum logic [1:0] {
    FlitBody   = 2'b00,
    FlitHead   = 2'b01,
    FlitTail   = 2'b10,
    FlitSingle = 2'b11
  } flit_type_e;

  // Callers pass flit[FLIT_W-1 -: 2], so this stays independent of the flit width.
  function automatic flit_type_e flit_type_of(input logic [1:0] type_field);
    return flit_type_e'(type_field);
  endfunction

endpackage

// File: rtl/flit_fifo_mem.sv
// Flit storage for the input buffer: DEPTH x FLIT_W register array.
//
// Ports:
//   clk_i    clock; the write happens on the rising edge
//   we_i     write enable
//   waddr_i  write index (0..DEPTH-1)
//   wdata_i  flit to store
//   raddr_i  read index (0..DEPTH-1)
//   rdata_o  asynchronous read data at raddr_i
//
// The array has no reset. Entries are only observed once the pointers say they are valid.
module flit_fifo_mem #(
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned DEPTH  = 5,
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PtrW-1:0]   waddr_i,
  input  logic [FLIT_W-1:0] wdata_i,
  input  logic [PtrW-1:0]   raddr_i,
  output logic [FLIT_W-1:0] rdata_o
);

  logic [FLIT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/input_buffer.sv
// Per-port input flit FIFO of a NoC router. It accepts flits from the upstream
// output port with no backpressure; flow control comes from credits. It returns one
// credit pulse per dequeued flit, presents the head-of-line flit to the route and
// crossbar stage, and tracks packet framing on the dequeue side.
//
// Ports:
//   clk           clock, all state updates on posedge
//   rst           asynchronous, active-low reset
//   flit_i        incoming flit (type in the top two bits)
//   valid_i       flit_i valid this cycle
//   flit_o        head-of-line flit (don't-care while valid_o=0)
//   valid_o       FIFO non-empty
//   ready_i       downstream takes flit_o when valid_o && ready_i
//   credit_o      one-cycle pulse in the cycle after each dequeue
//   occupancy_o   number of entries held
//   pkt_active_o  packet in progress on the dequeue side
//   err_o         {framing_err, overflow_err}, sticky until reset
//
// Build option: when INBUF_ERR_FLAG_EN is defined, err_o is backed by sticky error
// registers. Otherwise err_o is tied to 0. The datapath is identical in both builds.
module input_buffer
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = FlitWDefault,
  parameter int unsigned DEPTH  = DepthDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_W-1:0]          flit_i,
  input  logic                       valid_i,
  output logic [FLIT_W-1:0]          flit_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       credit_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic                       pkt_active_o,
  output logic [1:0]                 err_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    StIdle,
    StInPkt
  } frame_state_e;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            credit_q, credit_d;
  frame_state_e    state_q, state_d;

  logic       full;
  logic       enq;
  logic       deq;
  flit_type_e head_type;

  assign full    = (occ_q == OccW'(DEPTH));
  assign valid_o = (occ_q != '0);
  assign deq     = valid_o && ready_i;
  // When full, a same-cycle dequeue frees the slot the new flit takes.
  assign enq     = valid_i && (!full || deq);

  assign head_type = flit_type_of(flit_o[FLIT_W-1 -: 2]);

  flit_fifo_mem #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (enq),
    .waddr_i (wr_ptr_q),
    .wdata_i (flit_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (flit_o)
  );

  // Pointer, occupancy and credit next state. The wrap is explicit because DEPTH
  // need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    credit_d = deq;

    if (enq) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    if (enq && !deq) begin
      occ_d = occ_q + 1'b1;
    end else if (deq && !enq) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Framing FSM. It advances only on a dequeue. Illegal types leave the state unchanged.
  always_comb begin
    state_d = state_q;
    if (deq) begin
      unique case (head_type)
        FlitHead:   if (state_q == StIdle)  state_d = StInPkt;
        FlitTail:   if (state_q == StInPkt) state_d = StIdle;
        FlitBody:   ;
        FlitSingle: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      credit_q <= 1'b0;
      state_q  <= StIdle;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      credit_q <= credit_d;
      state_q  <= state_d;
    end
  end

  assign occupancy_o  = occ_q;
  assign credit_o     = credit_q;
  assign pkt_active_o = (state_q == StInPkt);

`ifdef INBUF_ERR_FLAG_EN
  logic       drop;
  logic       framing_err;
  logic [1:0] err_q, err_d;

  assign drop        = valid_i && full && !deq;
  assign framing_err = deq && (((state_q == StIdle) &&
                                ((head_type == FlitBody) || (head_type == FlitTail))) ||
                               ((state_q == StInPkt) &&
                                ((head_type == FlitHead) || (head_type == FlitSingle))));
  assign err_d       = err_q | {framing_err, drop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 2'b00;
`endif

endmodule
